// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream memory port between the fetch (I) and
// data (D) request buses. D wins ties unless fetch has been starved for
// STARVE_LIMIT consecutive D grants.
// Optional build macro ARB_PERF_CNT_EN adds perf_i_grants, perf_d_grants and
// perf_conflicts counters.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [31:0]       i_data,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [7:0]        d_strobe,
  input  logic [63:0]       d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [63:0]       d_rdata,
  output logic              c_valid,
  output logic [ADDR_W-1:0] c_addr,
  output logic [2:0]        c_size,
  output logic [7:0]        c_strobe,
  output logic [63:0]       c_wdata,
  input  logic              c_ready,
  input  logic              c_rvalid,
  input  logic [63:0]       c_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [2:0] FETCH_SIZE = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic              owner_d_q, owner_d_d;   // 1 = data bus owns the transaction
  logic              c_valid_q, c_valid_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [2:0]        c_size_q, c_size_d;
  logic [7:0]        c_strobe_q, c_strobe_d;
  logic [63:0]       c_wdata_q, c_wdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              grant_d;                // IDLE pick: 1 = D, 0 = I
  logic              resp_c;

  // Response arrives in WAIT, or together with acceptance in REQ.
  assign resp_c = c_rvalid && ((state_q == S_WAIT) || ((state_q == S_REQ) && c_ready));

  assign i_addr_ok = resp_c && !owner_d_q;
  assign i_data_ok = resp_c && !owner_d_q;
  assign d_addr_ok = resp_c && owner_d_q;
  assign d_data_ok = resp_c && owner_d_q;
  assign i_data    = i_data_ok ? (c_addr_q[2] ? c_rdata[63:32] : c_rdata[31:0]) : 32'h0;
  assign d_rdata   = d_data_ok ? c_rdata : 64'h0;

  assign c_valid  = c_valid_q;
  assign c_addr   = c_addr_q;
  assign c_size   = c_size_q;
  assign c_strobe = c_strobe_q;
  assign c_wdata  = c_wdata_q;

  // Grant selection, request latching and state transitions.
  always_comb begin
    state_d      = state_q;
    owner_d_d    = owner_d_q;
    c_valid_d    = c_valid_q;
    c_addr_d     = c_addr_q;
    c_size_d     = c_size_q;
    c_strobe_d   = c_strobe_q;
    c_wdata_d    = c_wdata_q;
    starve_cnt_d = starve_cnt_q;
    grant_d      = d_valid && !(i_valid && (starve_cnt_q == STARVE_MAX));
    unique case (state_q)
      S_IDLE: begin
        if (i_valid || d_valid) begin
          state_d   = S_REQ;
          owner_d_d = grant_d;
          c_valid_d = 1'b1;
          if (grant_d) begin
            c_addr_d   = d_addr;
            c_size_d   = d_size;
            c_strobe_d = d_strobe;
            c_wdata_d  = d_wdata;
            if (!i_valid)                       starve_cnt_d = '0;
            else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            c_addr_d     = i_addr;
            c_size_d     = FETCH_SIZE;
            c_strobe_d   = 8'h00;
            c_wdata_d    = 64'h0;
            starve_cnt_d = '0;
          end
        end
      end
      S_REQ: begin
        if (c_ready) begin
          c_valid_d = 1'b0;
          state_d   = c_rvalid ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (c_rvalid) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        c_valid_d = 1'b0;
      end
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_d_q    <= 1'b0;
      c_valid_q    <= 1'b0;
      c_addr_q     <= '0;
      c_size_q     <= '0;
      c_strobe_q   <= '0;
      c_wdata_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_d_q    <= owner_d_d;
      c_valid_q    <= c_valid_d;
      c_addr_q     <= c_addr_d;
      c_size_q     <= c_size_d;
      c_strobe_q   <= c_strobe_d;
      c_wdata_q    <= c_wdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_q, perf_i_d;
  logic [31:0] perf_d_q, perf_d_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  // Grant and conflict counters, wrapping.
  always_comb begin
    perf_i_d    = perf_i_q;
    perf_d_d    = perf_d_q;
    perf_conf_d = perf_conf_q;
    if (state_q == S_IDLE) begin
      if (i_valid && d_valid)  perf_conf_d = perf_conf_q + 32'd1;
      if (d_valid && grant_d)  perf_d_d    = perf_d_q + 32'd1;
      if (i_valid && !grant_d) perf_i_d    = perf_i_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_q    <= 32'h0;
      perf_d_q    <= 32'h0;
      perf_conf_q <= 32'h0;
    end else begin
      perf_i_q    <= perf_i_d;
      perf_d_q    <= perf_d_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  assign perf_i_grants  = perf_i_q;
  assign perf_d_grants  = perf_d_q;
  assign perf_conflicts = perf_conf_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (instantiated with STARVE_LIMIT=2).
module tb_mem_bus_arbiter;
  localparam int unsigned ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, i_addr_ok, i_data_ok;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_data;
  logic              d_valid, d_addr_ok, d_data_ok;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [7:0]        d_strobe;
  logic [63:0]       d_wdata, d_rdata;
  logic              c_valid, c_ready, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [2:0]        c_size;
  logic [7:0]        c_strobe;
  logic [63:0]       c_wdata, c_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]       perf_i_grants, perf_d_grants, perf_conflicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(2), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .c_valid(c_valid), .c_addr(c_addr), .c_size(c_size), .c_strobe(c_strobe), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream responder: waits (bounded) for c_valid, accepts, answers one cycle later.
  task automatic serve(input logic [63:0] rdata, output logic [ADDR_W-1:0] addr,
                       output logic [2:0] size, output logic [7:0] strobe, output logic [63:0] wdata,
                       output int wait_cyc, output logic [3:0] oks, output logic [31:0] idata,
                       output logic [63:0] drdata, output bit timeout);
    wait_cyc = 0; timeout = 1'b0; addr = '0; size = '0; strobe = '0; wdata = '0;
    oks = '0; idata = '0; drdata = '0;
    while (!c_valid && wait_cyc < 20) begin
      step();
      wait_cyc++;
    end
    if (!c_valid) begin
      timeout = 1'b1;
      return;
    end
    addr = c_addr; size = c_size; strobe = c_strobe; wdata = c_wdata;
    c_ready = 1'b1;
    step();
    c_ready  = 1'b0;
    c_rvalid = 1'b1;
    c_rdata  = rdata;
    @(negedge clk);
    oks    = {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok};
    idata  = i_data;
    drdata = d_rdata;
    @(posedge clk);
    #1;
    c_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
    c_ready = 0; c_rvalid = 0; c_rdata = '0;
    step(); step();
    n_checks++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c_valid: got %b want 0", c_valid); end
    n_checks++; if (c_addr !== '0) begin n_fail++; $display("FAIL reset_c_addr: got %h want 0", c_addr); end
    n_checks++; if ({c_size, c_strobe} !== 11'h0) begin n_fail++; $display("FAIL reset_c_size_strobe: got %h want 0", {c_size, c_strobe}); end
    n_checks++; if (c_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_c_wdata: got %h want 0", c_wdata); end
    n_checks++; if ({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 4'b0) begin n_fail++; $display("FAIL reset_oks: got %b want 0000", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    i_valid = 1'b1; i_addr = 64'h8000_0004;
    step();
    n_checks++; if (c_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_c_valid: got %b want 1", c_valid); end
    n_checks++; if (c_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL fetch_c_addr: got %h want 80000004", c_addr); end
    n_checks++; if (c_size !== 3'b010) begin n_fail++; $display("FAIL fetch_c_size: got %b want 010", c_size); end
    n_checks++; if ({c_strobe, c_wdata} !== 72'h0) begin n_fail++; $display("FAIL fetch_strobe_wdata: got %h want 0", {c_strobe, c_wdata}); end
    n_checks++; if (i_addr_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_early_addr_ok: got %b want 0", i_addr_ok); end
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
    n_checks++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_c_valid_drop: got %b want 0", c_valid); end
    step(); step();
    c_rvalid = 1'b1; c_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    n_checks++; if ({i_addr_ok, i_data_ok} !== 2'b11) begin n_fail++; $display("FAIL fetch_i_oks: got %b want 11", {i_addr_ok, i_data_ok}); end
    n_checks++; if (i_data !== 32'h1122_3344) begin n_fail++; $display("FAIL fetch_i_data: got %h want 11223344", i_data); end
    n_checks++; if ({d_addr_ok, d_data_ok, d_rdata} !== 66'h0) begin n_fail++; $display("FAIL fetch_d_quiet: got %h want 0", {d_addr_ok, d_data_ok, d_rdata}); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (i_data_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_width: got %b want 0", i_data_ok); end
    @(posedge clk); #1;
    c_rvalid = 1'b0;
  endtask

  task automatic test_conflict();
    logic [ADDR_W-1:0] a; logic [2:0] sz; logic [7:0] sb; logic [63:0] wd, dr;
    int wc; logic [3:0] ok; logic [31:0] id; bit to;
    i_valid = 1'b1; i_addr = 64'h1000;
    d_valid = 1'b1; d_addr = 64'h2008; d_size = 3'b011; d_strobe = 8'hFF; d_wdata = 64'hDEAD_BEEF;
    serve(64'hAAAA_BBBB_CCCC_DDDD, a, sz, sb, wd, wc, ok, id, dr, to);
    n_checks++; if (to !== 1'b0 || wc != 1) begin n_fail++; $display("FAIL conflict_d_latency: got timeout=%0d wait=%0d want 0/1", to, wc); end
    n_checks++; if (a !== 64'h2008) begin n_fail++; $display("FAIL conflict_d_first: got %h want 2008", a); end
    n_checks++; if ({sz, sb} !== {3'b011, 8'hFF}) begin n_fail++; $display("FAIL conflict_d_size_strobe: got %h want 3ff", {sz, sb}); end
    n_checks++; if (wd !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL conflict_d_wdata: got %h want deadbeef", wd); end
    n_checks++; if (ok !== 4'b0011) begin n_fail++; $display("FAIL conflict_d_oks: got %b want 0011", ok); end
    n_checks++; if (dr !== 64'hAAAA_BBBB_CCCC_DDDD) begin n_fail++; $display("FAIL conflict_d_rdata: got %h want aaaabbbbccccdddd", dr); end
    d_valid = 1'b0;
    serve(64'h0123_4567_89AB_CDEF, a, sz, sb, wd, wc, ok, id, dr, to);
    n_checks++; if (to !== 1'b0 || wc != 1) begin n_fail++; $display("FAIL conflict_i_turnaround: got timeout=%0d wait=%0d want 0/1", to, wc); end
    n_checks++; if (a !== 64'h1000) begin n_fail++; $display("FAIL conflict_i_second: got %h want 1000", a); end
    n_checks++; if (ok !== 4'b1100) begin n_fail++; $display("FAIL conflict_i_oks: got %b want 1100", ok); end
    n_checks++; if (id !== 32'h89AB_CDEF) begin n_fail++; $display("FAIL conflict_i_data_low: got %h want 89abcdef", id); end
    i_valid = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [ADDR_W-1:0] a; logic [2:0] sz; logic [7:0] sb; logic [63:0] wd, dr;
    int wc; logic [3:0] ok; logic [31:0] id; bit to;
    d_valid = 1'b1; d_addr = 64'h3000; d_size = 3'b011; d_strobe = 8'h00; d_wdata = '0;
    step();
    step(); step();
    n_checks++; if (c_valid !== 1'b1 || c_addr !== 64'h3000) begin n_fail++; $display("FAIL same_req_hold: got valid=%b addr=%h want 1/3000", c_valid, c_addr); end
    c_ready = 1'b1; c_rvalid = 1'b1; c_rdata = 64'h5555_6666_7777_8888;
    @(negedge clk);
    n_checks++; if ({i_data_ok, d_addr_ok, d_data_ok} !== 3'b011) begin n_fail++; $display("FAIL same_cycle_oks: got %b want 011", {i_data_ok, d_addr_ok, d_data_ok}); end
    n_checks++; if (d_rdata !== 64'h5555_6666_7777_8888) begin n_fail++; $display("FAIL same_cycle_rdata: got %h want 5555666677778888", d_rdata); end
    @(posedge clk); #1;
    c_ready = 1'b0; c_rvalid = 1'b0; d_valid = 1'b0;
    i_valid = 1'b1; i_addr = 64'h4000;
    step();
    n_checks++; if (c_valid !== 1'b1 || c_addr !== 64'h4000) begin n_fail++; $display("FAIL same_cycle_idle_next: got valid=%b addr=%h want 1/4000", c_valid, c_addr); end
    serve(64'h0, a, sz, sb, wd, wc, ok, id, dr, to);
    n_checks++; if (to !== 1'b0 || ok !== 4'b1100) begin n_fail++; $display("FAIL same_cycle_cleanup: got timeout=%0d oks=%b want 0/1100", to, ok); end
    i_valid = 1'b0;
  endtask

  task automatic test_starvation();
    logic [ADDR_W-1:0] a; logic [2:0] sz; logic [7:0] sb; logic [63:0] wd, dr;
    int wc; logic [3:0] ok; logic [31:0] id; bit to;
    logic [5:0] exp_is_d;
    exp_is_d = 6'b011011; // index 0 first: D,D,I,D,D,I
    i_valid = 1'b1; i_addr = 64'h1000;
    d_valid = 1'b1; d_addr = 64'h2000; d_size = 3'b011; d_strobe = 8'h00; d_wdata = '0;
    for (int k = 0; k < 6; k++) begin
      serve(64'(k), a, sz, sb, wd, wc, ok, id, dr, to);
      n_checks++;
      if (to !== 1'b0 || (a == 64'h2000) !== exp_is_d[k]) begin
        n_fail++;
        $display("FAIL starve_grant_%0d: got addr=%h timeout=%0d want is_d=%b", k, a, to, exp_is_d[k]);
      end
    end
    i_valid = 1'b0; d_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [ADDR_W-1:0] a; logic [2:0] sz; logic [7:0] sb; logic [63:0] wd, dr;
    int wc; logic [3:0] ok; logic [31:0] id; bit to;
    i_valid = 1'b1; i_addr = 64'h1000;
    d_valid = 1'b1; d_addr = 64'h2000;
    serve(64'h0, a, sz, sb, wd, wc, ok, id, dr, to);
    step();
    n_checks++; if (c_valid !== 1'b1 || c_addr !== 64'h2000) begin n_fail++; $display("FAIL rstwait_second_d: got valid=%b addr=%h want 1/2000", c_valid, c_addr); end
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
    i_valid = 1'b0; d_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (c_valid !== 1'b0 || c_addr !== '0) begin n_fail++; $display("FAIL rstwait_async_clear: got valid=%b addr=%h want 0/0", c_valid, c_addr); end
    step();
    rst = 1'b0;
    c_rvalid = 1'b1; c_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    n_checks++; if ({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 4'b0) begin n_fail++; $display("FAIL rstwait_stale_rvalid: got %b want 0000", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}); end
    @(posedge clk); #1;
    c_rvalid = 1'b0;
    n_checks++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle: got valid=%b want 0", c_valid); end
    i_valid = 1'b1; d_valid = 1'b1;
    serve(64'h0, a, sz, sb, wd, wc, ok, id, dr, to);
    n_checks++; if (to !== 1'b0 || a !== 64'h2000) begin n_fail++; $display("FAIL rstwait_starve_cleared: got addr=%h timeout=%0d want 2000/0", a, to); end
    i_valid = 1'b0; d_valid = 1'b0;
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    logic [ADDR_W-1:0] a; logic [2:0] sz; logic [7:0] sb; logic [63:0] wd, dr;
    int wc; logic [3:0] ok; logic [31:0] id; bit to;
    rst = 1'b1; step(); rst = 1'b0; step();
    i_valid = 1'b1; i_addr = 64'h1000; d_valid = 1'b1; d_addr = 64'h2000;
    serve(64'h0, a, sz, sb, wd, wc, ok, id, dr, to);
    d_valid = 1'b0;
    serve(64'h0, a, sz, sb, wd, wc, ok, id, dr, to);
    i_valid = 1'b0; d_valid = 1'b1;
    serve(64'h0, a, sz, sb, wd, wc, ok, id, dr, to);
    serve(64'h0, a, sz, sb, wd, wc, ok, id, dr, to);
    d_valid = 1'b0; i_valid = 1'b1;
    serve(64'h0, a, sz, sb, wd, wc, ok, id, dr, to);
    i_valid = 1'b0;
    n_checks++; if (perf_d_grants !== 32'd3) begin n_fail++; $display("FAIL perf_d_grants: got %0d want 3", perf_d_grants); end
    n_checks++; if (perf_i_grants !== 32'd2) begin n_fail++; $display("FAIL perf_i_grants: got %0d want 2", perf_i_grants); end
    n_checks++; if (perf_conflicts !== 32'd1) begin n_fail++; $display("FAIL perf_conflicts: got %0d want 1", perf_conflicts); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_same_cycle();
    test_starvation();
    test_reset_in_wait();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
